// File: rtl/gottagofast_pkg.sv
// gottagofast_pkg: state encoding, timing defaults and row/column address split
// shared by dram_sequencer and refresh_scheduler.
package gottagofast_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0, ROW = 3'd1, COLA = 3'd2, CAS = 3'd3,
    HOLD = 3'd4, PRE = 3'd5, RCAS = 3'd6, RRAS = 3'd7
  } state_t;
  localparam int REFRESH_INTERVAL = 110;
  localparam int MAX_DEBT = 7;
  localparam int T_RAS_REF = 2;
  localparam int T_RP = 1;
  localparam int ROW_HI = 22;
  localparam int ROW_LO = 11;
  localparam int COL_HI = 10;
  localparam int COL_LO = 1;
endpackage

// File: rtl/dram_sequencer_if.sv
// dram_sequencer_if: 68000 bus request side and DRAM strobe side of the sequencer.
interface dram_sequencer_if;
  logic        REQ, ASn, UDSn, LDSn, RWn;
  logic [22:1] ADDR;
  logic [11:0] MADDR;
  logic        RASn, UCASn, LCASn, OEn, MEMWn, XRDYn;
  modport master (output REQ, ASn, UDSn, LDSn, RWn, ADDR,
                  input  MADDR, RASn, UCASn, LCASn, OEn, MEMWn, XRDYn);
  modport slave  (input  REQ, ASn, UDSn, LDSn, RWn, ADDR,
                  output MADDR, RASn, UCASn, LCASn, OEn, MEMWn, XRDYn);
endinterface

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: refresh interval timer plus saturating refresh-debt counter (built with REFRESH_DEBT_EN).
`ifdef REFRESH_DEBT_EN
module refresh_scheduler
  import gottagofast_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic complete,
  output logic need,
  output logic urgent
);
  logic [6:0] cnt;
  logic [2:0] debt;
  logic       tick;
  assign tick   = cnt == 7'(REFRESH_INTERVAL - 1);
  assign need   = debt != 3'd0;
  assign urgent = debt == 3'(MAX_DEBT);
  // a tick and a completion in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      debt <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 7'd1;
      if (tick && !complete && !urgent) debt <= debt + 3'd1;
      else if (complete && !tick && need) debt <= debt - 3'd1;
    end
endmodule
`endif

// File: rtl/dram_sequencer.sv
// dram_sequencer: 68000 fast-RAM DRAM timing FSM. With REFRESH_DEBT_EN, refresh is
// scheduled by interval/debt and XRDYn stalls; otherwise refresh runs on every idle bus cycle.
module dram_sequencer
  import gottagofast_pkg::*;
(
  input  logic CLK,
  input  logic RESETn,
  dram_sequencer_if.slave bus
);
  state_t      st;
  logic [1:0]  cnt;
  logic [11:0] maddr;
  logic        ras_n, ucas_n, lcas_n, oe_n, xrdy_n;
  logic        ref_done, go_row, go_ref;
  assign ref_done = st == RRAS && cnt == 2'(T_RAS_REF);
`ifdef REFRESH_DEBT_EN
  logic need, urgent, stall;
  refresh_scheduler u_sched (
    .clk(CLK), .rst_n(RESETn), .complete(ref_done), .need(need), .urgent(urgent)
  );
  assign stall  = bus.REQ && !bus.ASn;
  assign go_row = bus.REQ && !urgent;
  assign go_ref = need && (!bus.REQ || urgent);
`else
  assign go_row = bus.REQ;
  assign go_ref = !bus.REQ && bus.ASn;
`endif
  assign bus.MADDR = maddr;
  assign bus.RASn  = ras_n;
  assign bus.UCASn = ucas_n;
  assign bus.LCASn = lcas_n;
  assign bus.OEn   = oe_n;
  assign bus.XRDYn = xrdy_n;
  assign bus.MEMWn = bus.RWn | (bus.UDSn & bus.LDSn) | (st != CAS);
  // strobes are registered from the current state, giving RAS at n+1 and CAS at n+3
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      st     <= IDLE;
      cnt    <= '0;
      maddr  <= '0;
      ras_n  <= 1'b1;
      ucas_n <= 1'b1;
      lcas_n <= 1'b1;
      oe_n   <= 1'b1;
      xrdy_n <= 1'b1;
    end else begin
`ifdef REFRESH_DEBT_EN
      xrdy_n <= !stall;
`endif
      case (st)
        IDLE:
          if (go_row) begin
            st     <= ROW;
            maddr  <= bus.ADDR[ROW_HI:ROW_LO];
            xrdy_n <= 1'b1;
          end else if (go_ref) st <= RCAS;
        ROW: begin
          xrdy_n <= 1'b1;
          ras_n  <= !bus.REQ;
          st     <= bus.REQ ? COLA : PRE;
        end
        COLA: begin
          xrdy_n <= 1'b1;
          ras_n  <= !bus.REQ;
          maddr  <= {2'b00, bus.ADDR[COL_HI:COL_LO]};
          st     <= !bus.REQ ? PRE : (bus.UDSn && bus.LDSn) ? COLA : CAS;
        end
        CAS: begin
          xrdy_n <= 1'b1;
          ucas_n <= bus.UDSn;
          lcas_n <= bus.LDSn;
          oe_n   <= !bus.RWn;
          st     <= HOLD;
        end
        HOLD: begin
          xrdy_n <= 1'b1;
          if (bus.ASn) begin
            st     <= PRE;
            ras_n  <= 1'b1;
            ucas_n <= 1'b1;
            lcas_n <= 1'b1;
            oe_n   <= 1'b1;
          end
        end
        PRE:
          if (cnt == 2'(T_RP - 1)) begin
            st  <= IDLE;
            cnt <= '0;
          end else cnt <= cnt + 2'd1;
        RCAS: begin
          ucas_n <= 1'b0;
          lcas_n <= 1'b0;
          st     <= RRAS;
        end
        RRAS:
          if (ref_done) begin
            st     <= PRE;
            cnt    <= '0;
            ras_n  <= 1'b1;
            ucas_n <= 1'b1;
            lcas_n <= 1'b1;
          end else begin
            ras_n <= 1'b0;
            cnt   <= cnt + 2'd1;
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dram_sequencer.sv
// tb_dram_sequencer: directed self-checking bench for dram_sequencer; debt/stall
// checks are compiled when REFRESH_DEBT_EN is defined, idle-refresh checks otherwise.
module tb_dram_sequencer;
  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;
  dram_sequencer_if bus ();
  dram_sequencer dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));
  always #5 CLK = ~CLK;
  // edges since reset release; the refresh interval wraps on multiples of 110
  always @(posedge CLK or negedge RESETn)
    if (!RESETn) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic req, input logic as_n, input logic uds_n,
                       input logic lds_n, input logic rw_n, input logic [21:0] addr);
    bus.REQ  = req;
    bus.ASn  = as_n;
    bus.UDSn = uds_n;
    bus.LDSn = lds_n;
    bus.RWn  = rw_n;
    bus.ADDR = addr;
  endtask
  task automatic ref_seq(input string tag);
    int i = 0;
    while (bus.UCASn === 1'b1 && i < 40) begin
      step();
      i++;
    end
    chk({tag, "_cas"}, {bus.RASn, bus.UCASn, bus.LCASn}, 3'b100);
    step();
    chk({tag, "_ras1"}, {bus.RASn, bus.UCASn, bus.LCASn}, 3'b000);
    step();
    chk({tag, "_ras2"}, {bus.RASn, bus.UCASn, bus.LCASn}, 3'b000);
    step();
    chk({tag, "_end"}, {bus.RASn, bus.UCASn, bus.LCASn}, 3'b111);
  endtask
  task automatic wait_xrdy();
    int i = 0;
    while (bus.XRDYn !== 1'b1 && i < 40) begin
      step();
      i++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(0, 1, 1, 1, 1, 22'h0);
    #23;
    chk("rst_strobes", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn, bus.MEMWn, bus.XRDYn}, 6'h3f);
    chk("rst_maddr", bus.MADDR, 12'h000);
    drive(0, 0, 1, 1, 1, 22'h0);
    step();
    RESETn = 1'b1;
`ifdef REFRESH_DEBT_EN
    while (cyc < 109) step();
    chk("debt_pre_tick", dut.u_sched.debt, 3'd0);
    step();
    chk("debt_tick", dut.u_sched.debt, 3'd1);
    ref_seq("int_ref");
    chk("debt_after_ref", dut.u_sched.debt, 3'd0);
`endif
    // read, both bytes
    repeat (3) step();
    drive(1, 0, 0, 0, 1, 22'h155E6F);
    step();
    chk("rd_row", {bus.RASn, bus.MADDR}, {1'b1, 12'h557});
    step();
    chk("rd_ras", {bus.RASn, bus.UCASn, bus.MADDR}, {2'b01, 12'h557});
    step();
    chk("rd_col", {bus.RASn, bus.MADDR, bus.UCASn, bus.LCASn}, {1'b0, 12'h26F, 2'b11});
    step();
    chk("rd_cas", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn, bus.MEMWn, bus.XRDYn}, 6'b000011);
    drive(0, 1, 1, 1, 1, 22'h155E6F);
    step();
    chk("rd_release", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn}, 4'hf);
    // lower-byte write
    drive(0, 0, 1, 1, 1, 22'h0);
    repeat (8) step();
    drive(1, 0, 1, 0, 0, 22'h000401);
    step();
    chk("wr_row", bus.MADDR, 12'h001);
    step();
    step();
    chk("wr_memw", {bus.MEMWn, bus.UCASn, bus.LCASn, bus.MADDR}, {3'b011, 12'h001});
    step();
    chk("wr_cas", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn, bus.MEMWn}, 5'b01011);
    drive(0, 1, 1, 1, 1, 22'h0);
    step();
    chk("wr_release", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn, bus.MEMWn}, 5'h1f);
    // data strobes late: wait in COLA, then abort
    drive(0, 0, 1, 1, 1, 22'h0);
    repeat (8) step();
    drive(1, 0, 1, 1, 0, 22'h3FFFFF);
    step();
    chk("ab_row", bus.MADDR, 12'hFFF);
    repeat (3) step();
    chk("ab_cola_wait", {bus.RASn, bus.UCASn, bus.LCASn, bus.MADDR}, {3'b011, 12'h3FF});
    drive(0, 0, 1, 1, 0, 22'h3FFFFF);
    step();
    chk("ab_abort", {bus.RASn, bus.UCASn, bus.LCASn}, 3'b111);
    step();
    chk("ab_no_cas", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn}, 4'hf);
`ifdef REFRESH_DEBT_EN
    // saturate the debt while parked in HOLD
    repeat (3) step();
    drive(1, 0, 0, 0, 1, 22'h155E6F);
    repeat (4) step();
    repeat (880) step();
    chk("debt_sat", dut.u_sched.debt, 3'd7);
    drive(0, 1, 1, 1, 1, 22'h155E6F);
    step();
    drive(1, 0, 0, 0, 1, 22'h155E6F);
    step();
    chk("sat_stall", bus.XRDYn, 1'b0);
    ref_seq("sat_ref");
    chk("sat_stall_ref", bus.XRDYn, 1'b0);
    wait_xrdy();
    chk("sat_release", {bus.XRDYn, bus.RASn, bus.MADDR}, {2'b11, 12'h557});
    step();
    chk("sat_ras", bus.RASn, 1'b0);
    drive(0, 1, 1, 1, 1, 22'h0);
    step();
`else
    drive(0, 1, 1, 1, 1, 22'h0);
    ref_seq("idle_ref");
    drive(1, 0, 0, 0, 1, 22'h155E6F);
    step();
    step();
    chk("def_row", {bus.XRDYn, bus.RASn, bus.MADDR}, {2'b11, 12'h557});
    drive(0, 1, 1, 1, 1, 22'h0);
    step();
`endif
    // asynchronous reset during HOLD
    drive(0, 0, 1, 1, 1, 22'h0);
    repeat (50) step();
    drive(1, 0, 0, 0, 1, 22'h155E6F);
    repeat (4) step();
    chk("hold_before_rst", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn}, 4'h0);
    #3 RESETn = 1'b0;
    #1;
    chk("rst_hold_strobes", {bus.RASn, bus.UCASn, bus.LCASn, bus.OEn, bus.XRDYn, bus.MEMWn}, 6'h3f);
    chk("rst_hold_maddr", bus.MADDR, 12'h000);
    chk("rst_hold_state", dut.st, 3'd0);
`ifdef REFRESH_DEBT_EN
    // refresh completion coincident with a tick at debt 3
    step();
    RESETn = 1'b1;
    while (cyc < 433) step();
    chk("coin_hold", {bus.RASn, bus.UCASn, dut.u_sched.debt}, {2'b00, 3'd3});
    drive(0, 1, 1, 1, 1, 22'h155E6F);
    while (cyc < 439) step();
    chk("coin_rras", {bus.RASn, bus.UCASn, dut.u_sched.debt}, {2'b00, 3'd3});
    step();
    chk("coin_exit", {bus.RASn, bus.UCASn, dut.u_sched.debt}, {2'b11, 3'd3});
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
